serial_divider: RTL and testbench
=================================

Name: serial_divider

Overview:
- Sequential restoring divider: the inverse companion of the team's shift-add serial multiplier.
- Uses the same En-start / done-pulse handshake, one quotient bit per iteration (shift cycle, then trial-subtract cycle).
- Sits beside the multiplier in the serial arithmetic unit; the host sees an identical start/done protocol for either operation.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- En  input  1  start request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned numerator; captured in LOAD.
- divisor  input  WIDTH  unsigned denominator; captured in LOAD.
- quotient  output  WIDTH  result; valid while done=1, held until next LOAD.
- remainder  output  WIDTH  result; valid while done=1, held until next LOAD.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high in every state except IDLE.
- div_by_zero  output  1  error flag; valid with done, held until next LOAD.

Behaviour:
- Reset (async, any state): state=IDLE. All registers clear: quotient, remainder, done, busy, div_by_zero, counter and internal R (WIDTH+1 bits), Q, D.
- States and transitions:
  - IDLE: done=0. En=1 -> LOAD.
  - LOAD: Q<=dividend, D<=divisor, R<=0, counter<=0, div_by_zero<=0.
    - divisor==0 -> DONE with quotient<=all ones, remainder<=dividend, div_by_zero<=1.
    - Otherwise -> SHIFT.
  - SHIFT: {R,Q} <= {R,Q}<<1 (Q[0]<=0) -> SUB.
  - SUB: diff = R - {1'b0,D}, computed at WIDTH+1 bits.
    - diff MSB=0: R<=diff, Q[0]<=1.
    - Else: R and Q unchanged.
    - counter<=counter+1.
    - counter+1==WIDTH -> DONE, quotient<=Q-next, remainder<=R-next[WIDTH-1:0]; else -> SHIFT.
  - DONE: done=1 for exactly this cycle -> IDLE.
- Timing: En sampled at edge 0 -> LOAD at edge 1 -> done high in the cycle after edge 1+2*WIDTH (edge 9 for WIDTH=4). Divide-by-zero: done high in the cycle after edge 1.
- busy=1 from the edge entering LOAD through the DONE cycle.
- En while busy: ignored, no effect on the running operation.
- En held high continuously: a new operation starts from IDLE, giving one idle cycle between operations.
- Operands may change after LOAD without affecting the result.
- Counter width: clog2(WIDTH)+1; it must reach WIDTH without wrapping.
- Rst asserted mid-operation: immediate return to IDLE with all outputs 0, no done pulse. The next En starts cleanly.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encodings (IDLE, LOAD, SHIFT, SUB, DONE as 3-bit localparams, distinct codes);
  - the default WIDTH constant, also used by the multiplier.
- One natural sub-module, serial_div_datapath:
  - contains the R/Q/D registers, shift and trial subtractor;
  - driven by load/shift/sub strobes from the FSM in serial_divider;
  - returns the diff sign bit.

Test Plan:
- 13/3, WIDTH=4: pulse En -> done in the cycle after edge 9; quotient=4, remainder=1, div_by_zero=0; busy high from edge 1 through edge 9.
- 15/1 and 7/9 back-to-back with En held high -> first quotient=15, remainder=0; second quotient=0, remainder=7; exactly one idle cycle between the done pulse and the next LOAD.
- 9/0 -> done in the cycle after edge 1; quotient=15, remainder=9, div_by_zero=1. A following 8/2 clears div_by_zero and gives quotient=4, remainder=0.
- Start 14/5, assert Rst asynchronously between clock edges after edge 4 -> all outputs 0 immediately, state IDLE, no done pulse. Re-issue 14/5 -> quotient=2, remainder=4.
- Start 12/4, toggle En and change dividend/divisor to 0 mid-operation -> result unaffected: quotient=3, remainder=0; exactly one done pulse.
- Exhaustive self-check, all 256 operand pairs at WIDTH=4 -> each result matches a/b and a%b (divide-by-zero pairs per rule above); done pulse width always 1 cycle.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic unit.
// State codes and default operand width.
package serial_arith_pkg;

  localparam int DEF_WIDTH = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_SHIFT = 3'd2;
  localparam state_t S_SUB   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/serial_divider_if.sv
// Host-side start/done bus for the serial divider.
// Host drives the master side, divider the slave side.
interface serial_divider_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             En;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output En,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  done,
    input  busy,
    input  div_by_zero
  );

  modport slave (
    input  En,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output done,
    output busy,
    output div_by_zero
  );

endinterface

// File: rtl/serial_div_datapath.sv
// Restoring-division datapath: partial remainder R,
// shifting quotient Q, captured divisor D, trial subtract.
module serial_div_datapath
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] diff_o,
  output logic [WIDTH-2:0] q_hi_o,
  output logic             diff_neg_o
);

  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;

  assign diff = r_q - {1'b0, d_q};

  // Next R/Q/D from the strobe issued by the FSM
  always_comb begin
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    if (load_i) begin
      r_d = '0;
      q_d = dividend_i;
      d_d = divisor_i;
    end else if (shift_i) begin
      {r_d, q_d} = {r_q, q_q} << 1;
    end else if (sub_i && !diff[WIDTH]) begin
      r_d = diff;
      q_d = {q_q[WIDTH-1:1], 1'b1};
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
    end
  end

  assign r_o        = r_q[WIDTH-1:0];
  assign diff_o     = diff[WIDTH-1:0];
  assign q_hi_o     = q_q[WIDTH-1:1];
  assign diff_neg_o = diff[WIDTH];

endmodule

// File: rtl/serial_divider.sv
// Sequential restoring divider, one quotient bit per
// shift/subtract pair, with a registered start/done bus.
module serial_divider
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             Rst,
  serial_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             load_s, shift_s, sub_s;
  logic             zero_s, last_s;
  logic [WIDTH-1:0] dp_r, dp_diff;
  logic [WIDTH-2:0] dp_q_hi;
  logic             dp_neg;

  assign zero_s = (bus.divisor == '0);
  assign last_s = (cnt_q == LAST);

  serial_div_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst        (Rst),
    .load_i     (load_s),
    .shift_i    (shift_s),
    .sub_i      (sub_s),
    .dividend_i (bus.dividend),
    .divisor_i  (bus.divisor),
    .r_o        (dp_r),
    .diff_o     (dp_diff),
    .q_hi_o     (dp_q_hi),
    .diff_neg_o (dp_neg)
  );

  // State register
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.En) state_d = S_LOAD;
      S_LOAD:  state_d = zero_s ? S_DONE : S_SHIFT;
      S_SHIFT: state_d = S_SUB;
      S_SUB:   state_d = last_s ? S_DONE : S_SHIFT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and next values of the registered outputs
  always_comb begin
    load_s  = (state_q == S_LOAD);
    shift_s = (state_q == S_SHIFT);
    sub_s   = (state_q == S_SUB);
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    if (load_s) begin
      cnt_d = '0;
      dz_d  = zero_s;
      if (zero_s) begin
        quo_d = '1;
        rem_d = bus.dividend;
      end
    end
    if (sub_s) begin
      cnt_d = cnt_q + 1'b1;
      if (last_s) begin
        quo_d = {dp_q_hi, ~dp_neg};
        rem_d = dp_neg ? dp_r : dp_diff;
      end
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // Counter and output registers
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider at WIDTH=4.
// Edge 0 is the clock edge that samples En in IDLE.
module tb_serial_divider;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_divider_if #(.WIDTH(4)) bus ();

  serial_divider #(.WIDTH(4)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse En for one edge, wait (bounded) for done,
  // return results, latency in edges after edge 0,
  // and whether done dropped on the following edge.
  task automatic run_op(input  logic [3:0] a,
                        input  logic [3:0] b,
                        output logic [3:0] q,
                        output logic [3:0] r,
                        output logic       z,
                        output int         lat,
                        output logic       pw_ok);
    bus.dividend = a;
    bus.divisor  = b;
    bus.En       = 1'b1;
    tick();
    bus.En = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    tick();
    pw_ok = !bus.done;
  endtask

  logic [3:0] q, r;
  logic       z, pw;
  int         lat, pulses;

  initial begin
    bus.En       = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    #12;
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    Rst = 1'b0;
    tick();
    tick();

    // 13/3 with per-edge timing
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    bus.En       = 1'b1;
    tick();
    bus.En = 1'b0;
    check("t1_busy_e0", bus.busy, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t1_busy_mid", bus.busy, 1);
      check("t1_done_early", bus.done, 0);
    end
    tick();
    check("t1_done_e9", bus.done, 1);
    check("t1_busy_e9", bus.busy, 1);
    check("t1_quotient", bus.quotient, 4);
    check("t1_remainder", bus.remainder, 1);
    check("t1_dbz", bus.div_by_zero, 0);
    tick();
    check("t1_done_e10", bus.done, 0);
    check("t1_busy_e10", bus.busy, 0);
    check("t1_hold_q", bus.quotient, 4);

    // 15/1 then 7/9 with En held high
    bus.dividend = 4'd15;
    bus.divisor  = 4'd1;
    bus.En       = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) tick();
    tick();
    check("t2a_done", bus.done, 1);
    check("t2a_quotient", bus.quotient, 15);
    check("t2a_remainder", bus.remainder, 0);
    bus.dividend = 4'd7;
    bus.divisor  = 4'd9;
    tick();
    check("t2_idle_busy", bus.busy, 0);
    check("t2_idle_done", bus.done, 0);
    tick();
    check("t2_reload_busy", bus.busy, 1);
    bus.En = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    check("t2b_not_yet", bus.done, 0);
    tick();
    check("t2b_done", bus.done, 1);
    check("t2b_quotient", bus.quotient, 0);
    check("t2b_remainder", bus.remainder, 7);
    tick();
    check("t2b_pulse", bus.done, 0);

    // 9/0 then 8/2
    run_op(4'd9, 4'd0, q, r, z, lat, pw);
    check("t3_latency", lat, 1);
    check("t3_quotient", q, 15);
    check("t3_remainder", r, 9);
    check("t3_dbz", z, 1);
    check("t3_pulse", pw, 1);
    check("t3_dbz_hold", bus.div_by_zero, 1);
    run_op(4'd8, 4'd2, q, r, z, lat, pw);
    check("t3b_latency", lat, 9);
    check("t3b_quotient", q, 4);
    check("t3b_remainder", r, 0);
    check("t3b_dbz", z, 0);

    // 14/5 aborted by async reset after edge 4
    bus.dividend = 4'd14;
    bus.divisor  = 4'd5;
    bus.En       = 1'b1;
    tick();
    bus.En = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    #2;
    Rst = 1'b1;
    #1;
    check("t4_rst_busy", bus.busy, 0);
    check("t4_rst_done", bus.done, 0);
    check("t4_rst_quotient", bus.quotient, 0);
    check("t4_rst_remainder", bus.remainder, 0);
    check("t4_rst_dbz", bus.div_by_zero, 0);
    #1;
    Rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done) pulses++;
    end
    check("t4_no_done", pulses, 0);
    check("t4_idle", bus.busy, 0);
    run_op(4'd14, 4'd5, q, r, z, lat, pw);
    check("t4b_latency", lat, 9);
    check("t4b_quotient", q, 2);
    check("t4b_remainder", r, 4);

    // 12/4 with En toggling and operands zeroed mid-run
    bus.dividend = 4'd12;
    bus.divisor  = 4'd4;
    bus.En       = 1'b1;
    tick();
    bus.En = 1'b0;
    tick();
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    pulses = 0;
    q = '0;
    r = '1;
    for (int k = 2; k <= 16; k++) begin
      bus.En = (k < 8) ? k[0] : 1'b0;
      tick();
      if (bus.done) begin
        pulses++;
        q = bus.quotient;
        r = bus.remainder;
      end
    end
    check("t5_pulses", pulses, 1);
    check("t5_quotient", q, 3);
    check("t5_remainder", r, 0);

    // All operand pairs
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), q, r, z, lat, pw);
        if (b == 0) begin
          check("ex_latency", lat, 1);
          check("ex_quotient", q, 15);
          check("ex_remainder", r, a);
          check("ex_dbz", z, 1);
        end else begin
          check("ex_latency", lat, 9);
          check("ex_quotient", q, a / b);
          check("ex_remainder", r, a % b);
          check("ex_dbz", z, 0);
        end
        check("ex_pulse", pw, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
